// File: rtl/lane_serializer_8b.sv
// Serializes one 32-bit lane word into four bytes, MSB first, at 4x the word rate.
// Back-to-back words stream gap-free; words offered while busy are dropped and flagged.
module lane_serializer_8b #(
   parameter logic [7:0] IDLE_SYM = 8'hBC
) (
   input  logic        clk_4f,
   input  logic        reset_L,
   input  logic [31:0] lane_in,
   input  logic        valid_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        ready_out,
   output logic        overflow_err
);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] hold_q, hold_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ovf_q, ovf_d;
   logic        accept;

   // Ready on the last byte of a word as well, so the next word follows with no gap.
   assign ready_out = reset_L & ((state_q == S_IDLE) | (cnt_q == 2'd0));
   assign accept    = valid_in & ready_out;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q | (valid_in & ~ready_out);
      if (accept) begin
         state_d = S_SEND;
         cnt_d   = 2'd3;
         hold_d  = lane_in[23:0];
         data_d  = lane_in[31:24];
         valid_d = 1'b1;
      end else if (state_q == S_SEND) begin
         if (cnt_q != 2'd0) begin
            cnt_d   = cnt_q - 2'd1;
            valid_d = 1'b1;
            case (cnt_q)
               2'd3:    data_d = hold_q[23:16];
               2'd2:    data_d = hold_q[15:8];
               default: data_d = hold_q[7:0];
            endcase
         end else begin
            state_d = S_IDLE;
            data_d  = IDLE_SYM;
            valid_d = 1'b0;
         end
      end else begin
         data_d  = IDLE_SYM;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         hold_q  <= 24'd0;
         data_q  <= IDLE_SYM;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_out     = data_q;
   assign valid_out    = valid_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_lane_serializer_8b.sv
// Scoreboard bench for lane_serializer_8b: the model tracks bytes still owed per word,
// pushes expected bytes on acceptance, and a negedge monitor pops and compares.
module tb_lane_serializer_8b;

   logic        clk_4f = 1'b0;
   logic        reset_L;
   logic [31:0] lane_in, lane1_in;
   logic        valid_in, valid1_in;
   logic [7:0]  data_out, data1_out;
   logic        valid_out, valid1_out;
   logic        ready_out, ready1_out;
   logic        overflow_err, overflow1_err;

   always #5 clk_4f = ~clk_4f;

   lane_serializer_8b u0 (
      .clk_4f(clk_4f), .reset_L(reset_L), .lane_in(lane_in), .valid_in(valid_in),
      .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
      .overflow_err(overflow_err));

   lane_serializer_8b u1 (
      .clk_4f(clk_4f), .reset_L(reset_L), .lane_in(lane1_in), .valid_in(valid1_in),
      .data_out(data1_out), .valid_out(valid1_out), .ready_out(ready1_out),
      .overflow_err(overflow1_err));

   int          errs = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got0[$], got1[$];
   int          left = 0;     // bytes of the current word still to appear on data_out
   bit          ovf_m = 1'b0;
   bit          dual = 1'b0;
   logic [7:0]  exp_b;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: outputs are stable at negedge, half a cycle after the active edge.
   always @(negedge clk_4f) begin
      if (reset_L) begin
         chk("valid_out", {31'd0, valid_out}, {31'd0, left > 0});
         chk("overflow_err", {31'd0, overflow_err}, {31'd0, ovf_m});
         if (valid_out) begin
            if (exp_q.size() == 0) chk("byte_without_word", exp_q.size(), 1);
            else begin
               exp_b = exp_q.pop_front();
               chk("data_out", {24'd0, data_out}, {24'd0, exp_b});
            end
            if (dual) got0.push_back(data_out);
         end else begin
            chk("idle_sym", {24'd0, data_out}, 32'hBC);
         end
         if (valid1_out) got1.push_back(data1_out);
      end
   end

   // One cycle of stimulus; the model state after the coming edge is updated here.
   task automatic drive(input bit v, input logic [31:0] w);
      @(negedge clk_4f); #1;
      chk("ready_out", {31'd0, ready_out}, {31'd0, left <= 1});
      valid_in = v;
      lane_in  = v ? w : 'x;
      if (v && left <= 1) begin
         for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
         left = 4;
      end else begin
         if (v) ovf_m = 1'b1;
         if (left > 0) left--;
      end
   endtask

   task automatic do_reset();
      reset_L   = 1'b0;
      valid_in  = 1'b0;
      valid1_in = 1'b0;
      #1;
      chk("rst_data_out", {24'd0, data_out}, 32'hBC);
      chk("rst_valid_out", {31'd0, valid_out}, 0);
      chk("rst_overflow", {31'd0, overflow_err}, 0);
      chk("rst_ready", {31'd0, ready_out}, 0);
      exp_q.delete();
      left  = 0;
      ovf_m = 1'b0;
      repeat (2) @(negedge clk_4f);
      #2 reset_L = 1'b1;
   endtask

   logic [31:0] s[8];
   logic [31:0] rebuilt;

   initial begin
      reset_L = 1'b1; valid_in = 1'b0; valid1_in = 1'b0; lane_in = '0; lane1_in = '0;
      #3;
      do_reset();

      // Idle: ready and COM symbol held throughout
      repeat (20) drive(0, 0);

      // Single word, then back-to-back pair presented on the last byte
      drive(1, 32'hA1B2C3D4);
      repeat (5) drive(0, 0);
      drive(1, 32'h11223344);
      repeat (3) drive(0, 0);
      drive(1, 32'h55667788);
      repeat (6) drive(0, 0);

      // Overflow: a new word every cycle, only every 4th accepted
      repeat (12) drive(1, $urandom);
      repeat (6) drive(0, 0);

      // Mid-word reset while B2 is on data_out (overflow is set beforehand)
      drive(1, 32'hA1B2C3D4);
      drive(0, 0);
      @(negedge clk_4f); #2;
      chk("pre_reset_byte", {24'd0, data_out}, 32'hB2);
      do_reset();
      repeat (8) drive(0, 0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) drive(1, $urandom);
         else drive(0, 0);
      end
      repeat (6) drive(0, 0);

      // Dual lane: striped stream rebuilt by interleaving lane words
      for (int i = 0; i < 8; i++) s[i] = $urandom;
      got0.delete(); got1.delete();
      dual = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1, s[2*k]);
         lane1_in = s[2*k+1]; valid1_in = 1'b1;
         for (int j = 0; j < 3; j++) begin
            drive(0, 0);
            valid1_in = 1'b0; lane1_in = 'x;
         end
      end
      repeat (5) drive(0, 0);
      dual = 1'b0;
      chk("lane0_bytes", got0.size(), 16);
      chk("lane1_bytes", got1.size(), 16);
      if (got0.size() == 16 && got1.size() == 16) begin
         for (int i = 0; i < 8; i++) begin
            rebuilt = '0;
            for (int b = 0; b < 4; b++)
               rebuilt = {rebuilt[23:0], (i % 2 == 0) ? got0[(i/2)*4 + b] : got1[(i/2)*4 + b]};
            chk("dual_rebuild", rebuilt, s[i]);
         end
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
